// File: rtl/vector_checksum.sv
// Frame checksum engine: pulls nb_frame vectors from an upstream buffer and
// reports their mod-256 sum and XOR parity, with an idle timeout per vector.
module vector_checksum #(
  parameter int unsigned nb_frame = 4,
  parameter int unsigned timeout  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       req,
  input  logic [7:0] vector,
  input  logic       valid,
  output logic [7:0] sum,
  output logic [7:0] parity,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned cnt_w = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Limits widened by one bit so the "+1" compares never wrap.
  localparam logic [cnt_w:0] frame_len = nb_frame[cnt_w:0];
  localparam logic [cnt_w:0] idle_lim  = timeout[cnt_w:0];
  localparam logic [cnt_w:0] one_ext   = {{cnt_w{1'b0}}, 1'b1};

  state_t           state;
  logic [cnt_w-1:0] count;
  logic [cnt_w-1:0] idle_cnt;
  logic [cnt_w:0]   count_inc;
  logic [cnt_w:0]   idle_inc;

  assign count_inc = {1'b0, count} + one_ext;
  assign idle_inc  = {1'b0, idle_cnt} + one_ext;

  // Handshake and status flags decode directly from the state register.
  assign req  = (state == FETCH);
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sum      <= 8'h00;
      parity   <= 8'h00;
      count    <= '0;
      idle_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum      <= 8'h00;
            parity   <= 8'h00;
            count    <= '0;
            idle_cnt <= '0;
            err      <= 1'b0;
            state    <= FETCH;
          end
        end

        FETCH: begin
          // A transfer wins over a timeout landing in the same cycle.
          if (valid) begin
            sum      <= sum + vector;
            parity   <= parity ^ vector;
            count    <= count_inc[cnt_w-1:0];
            idle_cnt <= '0;
            if (count_inc == frame_len) begin
              state <= FINISH;
            end
          end else begin
            idle_cnt <= idle_inc[cnt_w-1:0];
            if (idle_inc == idle_lim) begin
              err   <= 1'b1;
              state <= FINISH;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checksum.sv
// Scoreboard bench for vector_checksum: default-size instance plus a
// two-vector-frame instance sharing the vector/valid stimulus.
module tb_vector_checksum;

  typedef struct packed {
    logic [7:0] sum;
    logic [7:0] parity;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic       valid;
  logic [7:0] vector;

  logic       req,  busy,  done,  err;
  logic [7:0] sum,  parity;
  logic       req2, busy2, done2, err2;
  logic [7:0] sum2, parity2;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q1[$];
  exp_t q2[$];
  logic [7:0] vals [0:3];

  always #5 clk = ~clk;

  vector_checksum u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .req    (req),
    .vector (vector),
    .valid  (valid),
    .sum    (sum),
    .parity (parity),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  vector_checksum #(.nb_frame(2), .timeout(15)) u_dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .req    (req2),
    .vector (vector),
    .valid  (valid),
    .sum    (sum2),
    .parity (parity2),
    .busy   (busy2),
    .done   (done2),
    .err    (err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sel_req(input int w);
    return (w != 0) ? req2 : req;
  endfunction

  function automatic logic sel_done(input int w);
    return (w != 0) ? done2 : done;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done1_unexpected: got done=1 expected no pulse at %0t", $time);
      end else begin
        e = q1.pop_front();
        check("dut1_sum", 32'(sum), 32'(e.sum));
        check("dut1_parity", 32'(parity), 32'(e.parity));
        check("dut1_err", 32'(err), 32'(e.err));
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done2_unexpected: got done=1 expected no pulse at %0t", $time);
      end else begin
        e = q2.pop_front();
        check("dut2_sum", 32'(sum2), 32'(e.sum));
        check("dut2_parity", 32'(parity2), 32'(e.parity));
        check("dut2_err", 32'(err2), 32'(e.err));
      end
    end
  end

  // Start a frame, then offer vals[] with valid every `period` cycles.
  task automatic feed(input int w, input int n, input int period, input bit hold_start,
                      output int req_cyc);
    int  idx;
    int  cyc;
    logic r;
    idx     = 0;
    cyc     = 0;
    req_cyc = 0;
    @(negedge clk);
    if (w != 0) start2 = 1'b1;
    else        start  = 1'b1;
    @(negedge clk);
    if (!hold_start) begin
      start  = 1'b0;
      start2 = 1'b0;
    end
    while (idx < n && cyc < 300 && !sel_done(w)) begin
      valid  = ((cyc % period) == 0);
      vector = valid ? vals[idx] : 8'hEE;
      r      = sel_req(w);
      @(negedge clk);
      if (r && valid) idx++;
      if (r) req_cyc++;
      cyc++;
    end
    valid = 1'b0;
    if (cyc >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_bound: got %0d transfers expected %0d", idx, n);
    end
  endtask

  // Count cycles until done, then step into IDLE.
  task automatic wait_done(input int w, output int cyc);
    cyc = 0;
    while (!sel_done(w) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!sel_done(w)) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: got no done expected pulse within 100 cycles");
    end
    @(negedge clk);
  endtask

  initial begin
    int rc;
    int c;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    valid  = 1'b0;
    vector = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_parity", 32'(parity), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", 32'(busy), 0);

    // Timeout after a single transfer
    vals[0] = 8'h55;
    q1.push_back('{sum: 8'h55, parity: 8'h55, err: 1'b1});
    feed(0, 1, 1, 1'b0, rc);
    wait_done(0, c);
    check("t4_idle_cycles", 32'(c), 15);
    repeat (3) @(negedge clk);
    check("hold_err", 32'(err), 1);
    check("hold_sum", 32'(sum), 32'h55);
    check("hold_busy", 32'(busy), 0);

    // Default frame, back-to-back
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
    q1.push_back('{sum: 8'h0A, parity: 8'h04, err: 1'b0});
    feed(0, 4, 1, 1'b0, rc);
    check("t1_req_cycles", 32'(rc), 4);
    wait_done(0, c);
    check("t1_done_latency", 32'(c), 0);

    // 8-bit wrap on a two-vector frame
    vals[0] = 8'hF0; vals[1] = 8'h20;
    q2.push_back('{sum: 8'h10, parity: 8'hD0, err: 1'b0});
    feed(1, 2, 1, 1'b0, rc);
    check("t2_req_cycles", 32'(rc), 2);
    wait_done(1, c);

    // Stalls: valid every third cycle
    vals[0] = 8'h11; vals[1] = 8'h11; vals[2] = 8'h11; vals[3] = 8'h11;
    q1.push_back('{sum: 8'h44, parity: 8'h00, err: 1'b0});
    feed(0, 4, 3, 1'b0, rc);
    check("t3_req_cycles", 32'(rc), 10);
    wait_done(0, c);

    // Transfer on the cycle the idle counter would hit timeout
    vals[0] = 8'h0F; vals[1] = 8'h01;
    q2.push_back('{sum: 8'h10, parity: 8'h0E, err: 1'b0});
    feed(1, 2, 15, 1'b0, rc);
    check("prio_req_cycles", 32'(rc), 16);
    wait_done(1, c);
    check("prio_done_latency", 32'(c), 0);

    // valid in IDLE ignored; start held through FETCH and FINISH ignored
    valid  = 1'b1;
    vector = 8'hFF;
    repeat (3) @(negedge clk);
    check("t6_idle_valid_sum", 32'(sum), 32'h44);
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h04; vals[3] = 8'h08;
    q1.push_back('{sum: 8'h0F, parity: 8'h0F, err: 1'b0});
    feed(0, 4, 2, 1'b1, rc);
    check("t6_req_cycles", 32'(rc), 7);
    wait_done(0, c);
    check("t6_done_latency", 32'(c), 0);
    start = 1'b0;
    @(negedge clk);
    check("t6_no_restart", 32'(busy), 0);

    // Reset mid-frame with start asserted alongside it
    vals[0] = 8'hAA; vals[1] = 8'h55;
    feed(0, 2, 1, 1'b0, rc);
    check("t5_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("t5_req", 32'(req), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_sum", 32'(sum), 0);
    check("t5_parity", 32'(parity), 0);
    check("t5_done", 32'(done), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("t5_start_in_reset", 32'(busy), 0);
    repeat (3) @(negedge clk);

    check("q1_drained", 32'(q1.size()), 0);
    check("q2_drained", 32'(q2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_checksum.md
VECTOR_CHECKSUM -- requirements
Module: vector_checksum

Interface
REQ-001 The block SHALL have parameter nb_frame, default 4, giving vectors consumed per frame (legal 1..255).
REQ-002 The block SHALL have parameter timeout, default 15, giving max idle cycles waiting for a vector (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, requesting one frame checksum; sampled only in IDLE.
REQ-006 The block SHALL have port req, output, 1, requesting the next vector from the upstream vector buffer.
REQ-007 The block SHALL have port vector, input, 8, the data vector from the upstream buffer.
REQ-008 The block SHALL have port valid, input, 1, marking vector as meaningful.
REQ-009 The block SHALL have port sum, output, 8, the mod-256 sum of the accepted vectors of the last frame.
REQ-010 The block SHALL have port parity, output, 8, the bitwise XOR of the accepted vectors of the last frame.
REQ-011 The block SHALL have port busy, output, 1, high while a frame is in progress.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse when a frame ends.
REQ-013 The block SHALL have port err, output, 1, set when the last frame ended by timeout.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, FETCH and FINISH.
REQ-015 In IDLE with start=1, the block SHALL clear the accumulators, vector count and idle counter, clear err, and enter FETCH on the next edge.
REQ-016 In FETCH, the block SHALL drive req=1 combinationally from state; in IDLE and FINISH, req SHALL be 0.
REQ-017 A transfer SHALL occur only on a rising edge where req=1 and valid=1; valid without req SHALL be ignored.
REQ-018 On a transfer: sum <= sum + vector (carry discarded, 8-bit wrap); parity <= parity ^ vector; count increments; idle counter clears.
REQ-019 Transfer latency SHALL be zero: valid may arrive in the same cycle req rises, and back-to-back transfers SHALL be accepted every cycle.
REQ-020 When the transfer bringing count to nb_frame occurs, the block SHALL enter FINISH on that edge.
REQ-021 In FETCH with no transfer, the idle counter SHALL increment; when it reaches timeout, the block SHALL set err=1 and enter FINISH with partial sum and parity kept.
REQ-022 A transfer in the cycle the idle counter would reach timeout SHALL take priority; no error SHALL be raised.
REQ-023 In FINISH, done SHALL be 1 for exactly one cycle; the block SHALL then return to IDLE.
REQ-024 busy SHALL be 1 in FETCH and FINISH and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored and SHALL NOT restart or extend the frame.
REQ-026 start in the FINISH cycle SHALL be ignored; a new frame SHALL begin only from IDLE.
REQ-027 sum, parity and err SHALL hold their values in IDLE until the next accepted start.
REQ-028 The vector count and idle counter SHALL be 8 bits wide.

Reset
REQ-029 On a rising edge with rst_n=0, the block SHALL enter IDLE and set sum=0, parity=0, count=0, idle counter=0, err=0 and done=0; this SHALL override all other events.
REQ-030 Reset during FETCH SHALL abandon the frame with no done pulse; req SHALL be 0 in the following cycle.
REQ-031 After reset is released, the block SHALL wait in IDLE for start; a start asserted in the cycle rst_n=0 SHALL NOT be honoured.

Verification
REQ-032 Test 1 SHALL check the default frame: start, then valid held high with vectors 0x01,0x02,0x03,0x04. Required: req high for 4 cycles; then done pulse, sum=0x0A, parity=0x04, err=0.
REQ-033 Test 2 SHALL check wrap: nb_frame=2 with vectors 0xF0,0x20. Required: sum=0x10, parity=0xD0.
REQ-034 Test 3 SHALL check stalls: valid given only every 3rd cycle with 0x11 x4. Required: done after 4 transfers, sum=0x44, parity=0x00, err=0.
REQ-035 Test 4 SHALL check timeout: timeout=15, one transfer of 0x55, then valid=0. Required: done and err=1 once 15 idle cycles are reached, sum=0x55.
REQ-036 Test 5 SHALL check reset mid-frame: rst_n=0 after 2 transfers. Required: next cycle req=0, busy=0, sum=0, no done pulse.
REQ-037 Test 6 SHALL check ignored inputs: start pulses while busy, and valid=1 while in IDLE. Required: frame result unchanged and no extra transfers counted.
